lifo_fifo_dual: RTL
===================

// Module: lifo_fifo_dual
// PURPOSE
//   Parametrised successor of the single-mode stack buffer: one storage array run as
//   LIFO (stack) or FIFO (queue), selected at runtime while the buffer is empty.
//   Adds registered read data with a valid strobe, explicit simultaneous rd/wr rules,
//   sticky overflow/underflow flags and a synchronous flush. Used between packet
//   builders and parsers that need either reverse or in-order replay of words.
// PARAMETERS
//   DWIDTH        16  data word width, bits
//   AWIDTH        8   address width; DEPTH = 2**AWIDTH words
//   ALMOST_FULL   2   almost_full_o threshold, words (1..DEPTH)
//   ALMOST_EMPTY  2   almost_empty_o threshold, words (1..DEPTH)
// PORTS
//   clk_i           in   1         clock, all logic on rising edge
//   srst_i          in   1         reset, asynchronous, active-high
//   mode_i          in   1         requested mode: 0 = LIFO, 1 = FIFO
//   flush_i         in   1         synchronous clear of contents and error flags
//   wrreq_i         in   1         write request
//   data_i          in   DWIDTH    write data
//   rdreq_i         in   1         read request
//   q_o             out  DWIDTH    read data, registered
//   q_valid_o       out  1         1-cycle strobe: q_o holds data of an accepted read
//   mode_o          out  1         active mode
//   almost_empty_o  out  1         usedw_o < ALMOST_EMPTY
//   empty_o         out  1         usedw_o == 0
//   almost_full_o   out  1         usedw_o >= ALMOST_FULL
//   full_o          out  1         usedw_o == DEPTH
//   usedw_o         out  AWIDTH+1  stored word count, 0..DEPTH
//   overflow_o      out  1         sticky: write dropped while full
//   underflow_o     out  1         sticky: read ignored while empty
// BEHAVIOUR
//   Reset (async assert, sync release): pointers/usedw 0, q_o 0, q_valid_o 0, mode_o 0,
//     overflow/underflow 0; empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0.
//   All flags are registered, derived from next usedw; valid the cycle after the op.
//   Acceptance: rd_acc = rdreq_i & ~empty; wr_acc = wrreq_i & (~full | rd_acc).
//   Read latency 1: q_o/q_valid_o update on the edge after rd_acc; q_o holds otherwise.
//   LIFO: write to mem[usedw]; read mem[usedw-1]. rd_acc & wr_acc: q_o <= old top,
//     data_i overwrites mem[usedw-1], usedw unchanged (valid also when full).
//   FIFO: wr_ptr/rd_ptr AWIDTH bits, wrap modulo DEPTH. rd_acc & wr_acc: usedw
//     unchanged, both pointers advance; legal when full. Read-during-write to same
//     slot never occurs (empty read is rejected).
//   Empty + rdreq_i + wrreq_i: write accepted, read ignored, underflow_o set.
//   Full + wrreq_i without rdreq_i: write dropped, overflow_o set, contents intact.
//   Mode: mode_o <= mode_i only on cycles with usedw==0 and wrreq_i==0 and no flush;
//     otherwise mode_i ignored. Pointers reset to 0 on mode change.
//   flush_i (priority over rd/wr): usedw/pointers 0, overflow/underflow 0, no q_valid_o,
//     q_o holds; memory contents not cleared; same-cycle rd/wr discarded.
//   Memory: single array, 1 write + 1 read port, inferable as simple dual-port RAM.
// TESTING (DWIDTH=16, AWIDTH=3, ALMOST_FULL=6, ALMOST_EMPTY=2)
//   LIFO: write 1..8 -> full_o=1, almost_full_o=1, usedw_o=8; 8 reads -> q_o 8,7..1,
//     each with q_valid_o 1 cycle after rdreq_i; then empty_o=1.
//   FIFO: mode_i=1 while empty; write 10 words with interleaved reads keeping usedw<=8
//     -> reads return write order across pointer wrap; no error flags.
//   Simultaneous: LIFO holding A,B; rd+wr C -> q_o=B, usedw_o=2; next read -> C.
//     FIFO full 1..8, rd+wr 9 -> q_o=1, full_o stays 1; drain -> 2..9.
//   Errors: write while full -> overflow_o=1, data intact; read while empty ->
//     underflow_o=1, no q_valid_o; flush_i -> both 0, usedw_o=0, empty_o=1.
//   Mode lock: 3 words in LIFO, toggle mode_i -> mode_o stays 0; after drain and
//     idle cycle mode_o=1.
//   Reset: assert srst_i mid-stream (usedw 5) asynchronously -> outputs reach reset
//     values without a clock edge; post-release write/read behave as fresh LIFO.

Source files
------------

// File: rtl/lifo_fifo_dual.sv
// lifo_fifo_dual: one storage array run either as a stack (LIFO) or a queue (FIFO).
// Mode is latched only while the buffer is empty, so stored data always has a single
// consistent ordering. Read data is registered with a one-cycle valid strobe, status
// flags are registered from the next word count, and error flags are sticky until flush.
module lifo_fifo_dual #(
   parameter int DWIDTH       = 16,
   parameter int AWIDTH       = 8,
   parameter int ALMOST_FULL  = 2,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              mode_i,
   input  logic              flush_i,
   input  logic              wrreq_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              rdreq_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              q_valid_o,
   output logic              mode_o,
   output logic              almost_empty_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic              full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int DEPTH = 1 << AWIDTH;
   localparam logic [AWIDTH:0] C_DEPTH = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] C_AFULL = (AWIDTH+1)'(ALMOST_FULL);
   localparam logic [AWIDTH:0] C_AEMPTY = (AWIDTH+1)'(ALMOST_EMPTY);

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [DWIDTH-1:0] r_q;
   logic              r_q_valid;
   logic              r_mode;
   logic [AWIDTH:0]   r_usedw;
   logic [AWIDTH-1:0] r_wr_ptr;
   logic [AWIDTH-1:0] r_rd_ptr;
   logic              r_empty;
   logic              r_full;
   logic              r_almost_empty;
   logic              r_almost_full;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_mode_load;
   logic [AWIDTH:0]   w_usedw_next;
   logic [AWIDTH-1:0] w_wr_addr;
   logic [AWIDTH-1:0] w_rd_addr;
   logic [AWIDTH-1:0] w_top_addr;

   // Flush overrides both requests; a full buffer still takes a write paired with a read.
   assign w_rd_acc    = rdreq_i & ~r_empty & ~flush_i;
   assign w_wr_acc    = wrreq_i & (~r_full | w_rd_acc) & ~flush_i;
   assign w_mode_load = r_empty & ~wrreq_i & ~flush_i;
   assign w_top_addr  = AWIDTH'(r_usedw - 1'b1);

   // Address selection: the stack's simultaneous read/write replaces the top word in place.
   always_comb begin
      w_wr_addr = r_usedw[AWIDTH-1:0];
      w_rd_addr = w_top_addr;
      if (r_mode) begin
         w_wr_addr = r_wr_ptr;
         w_rd_addr = r_rd_ptr;
      end else if (w_rd_acc && w_wr_acc) begin
         w_wr_addr = w_top_addr;
      end
   end

   // Next word count; a paired read and write leaves it unchanged.
   always_comb begin
      w_usedw_next = r_usedw;
      if (flush_i)
         w_usedw_next = '0;
      else if (w_wr_acc && !w_rd_acc)
         w_usedw_next = r_usedw + 1'b1;
      else if (w_rd_acc && !w_wr_acc)
         w_usedw_next = r_usedw - 1'b1;
   end

   // Storage write port, kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (w_wr_acc)
         r_mem[w_wr_addr] <= data_i;
   end

   // Registered read port; samples the old word when the same slot is overwritten.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         r_q       <= '0;
         r_q_valid <= 1'b0;
      end else begin
         r_q_valid <= w_rd_acc;
         if (w_rd_acc)
            r_q <= r_mem[w_rd_addr];
      end
   end

   // Count, queue pointers and mode; pointers restart whenever the mode may be reloaded.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         r_usedw  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mode   <= 1'b0;
      end else begin
         r_usedw <= w_usedw_next;
         if (flush_i || w_mode_load) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else if (r_mode) begin
            if (w_wr_acc)
               r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc)
               r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_mode_load)
            r_mode <= mode_i;
      end
   end

   // Status flags registered from the next count; error flags sticky until flush.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         r_empty        <= 1'b1;
         r_full         <= 1'b0;
         r_almost_empty <= 1'b1;
         r_almost_full  <= 1'b0;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_empty        <= (w_usedw_next == '0);
         r_full         <= (w_usedw_next == C_DEPTH);
         r_almost_empty <= (w_usedw_next < C_AEMPTY);
         r_almost_full  <= (w_usedw_next >= C_AFULL);
         if (flush_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (wrreq_i && !w_wr_acc)
               r_overflow <= 1'b1;
            if (rdreq_i && r_empty)
               r_underflow <= 1'b1;
         end
      end
   end

   assign q_o            = r_q;
   assign q_valid_o      = r_q_valid;
   assign mode_o         = r_mode;
   assign usedw_o        = r_usedw;
   assign empty_o        = r_empty;
   assign full_o         = r_full;
   assign almost_empty_o = r_almost_empty;
   assign almost_full_o  = r_almost_full;
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

endmodule
